skip_mult_counter: RTL and testbench

- Free-running up-counter that emits 0 and then every positive integer that is not a multiple of a runtime-selectable modulus M.
- Generalised successor of the fixed skip-multiples-of-3 counter. Adds configurable width, runtime modulus, programmable wrap limit, enable, synchronous clear, and status pulses.
- Used as a sequence/address generator for stimulus engines and interleavers.

---
 rtl/skip_mult_counter.sv | 84 ++++++++
 tb/tb_skip_mult_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skip_mult_counter.sv
// Up-counter that emits 0 and then every positive integer that is not a multiple of a runtime modulus.
// The residue is tracked incrementally, so no divider is needed; a programmable limit and overflow both return the count to 0.
module skip_mult_counter #(
    parameter int BW      = 8,
    parameter int MW      = 4,
    parameter int DEF_MOD = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [MW-1:0] mod_i,
    input  logic [BW-1:0] lim_i,
    output logic [BW-1:0] countout,
    output logic          skip,
    output logic          wrap
);

    localparam logic [MW-1:0] DEF_MOD_Q = MW'(DEF_MOD);

    logic [MW-1:0] r;
    logic [MW-1:0] mod_q;
    logic [MW-1:0] r_nxt;
    logic [MW-1:0] mod_nxt;
    logic [BW-1:0] cnt_nxt;
    logic          skip_nxt;
    logic          wrap_nxt;
    logic          skip_mode;
    logic          step2;
    logic [BW:0]   sum;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        cnt_nxt   = countout;
        r_nxt     = r;
        mod_nxt   = mod_q;
        skip_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        skip_mode = (mod_q >= MW'(2));
        // The residue equals mod_q-1 exactly when countout+1 would be a multiple of mod_q.
        step2     = skip_mode && (r == mod_q - MW'(1));
        sum       = {1'b0, countout} + (step2 ? (BW+1)'(2) : (BW+1)'(1));

        if (clr) begin
            cnt_nxt = '0;
            r_nxt   = '0;
            mod_nxt = mod_i;
        end else if (en) begin
            if ((sum > {1'b0, lim_i}) || sum[BW]) begin
                cnt_nxt  = '0;
                r_nxt    = '0;
                mod_nxt  = mod_i;
                wrap_nxt = 1'b1;
            end else begin
                cnt_nxt  = sum[BW-1:0];
                skip_nxt = step2;
                if (!skip_mode)
                    r_nxt = '0;
                else if (step2)
                    r_nxt = MW'(1);
                else
                    r_nxt = r + MW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countout <= '0;
            r        <= '0;
            mod_q    <= DEF_MOD_Q;
            skip     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            countout <= cnt_nxt;
            r        <= r_nxt;
            mod_q    <= mod_nxt;
            skip     <= skip_nxt;
            wrap     <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_skip_mult_counter.sv
// Self-checking bench for skip_mult_counter: directed sequences with literal expectations,
// then randomized traffic compared every cycle against an arithmetic model using the % operator.
module tb_skip_mult_counter;

    localparam int BW = 8;
    localparam int MW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr;
    logic [MW-1:0] mod_i;
    logic [BW-1:0] lim_i;
    logic [BW-1:0] countout;
    logic          skip;
    logic          wrap;

    int errors = 0;
    int checks = 0;

    skip_mult_counter #(.BW(BW), .MW(MW), .DEF_MOD(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .mod_i    (mod_i),
        .lim_i    (lim_i),
        .countout (countout),
        .skip     (skip),
        .wrap     (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int cnt;
        int mod;
        bit skip;
        bit wrap;
    } mstate_t;

    mstate_t m = '{0, 3, 1'b0, 1'b0};

    // Next emitted value is the smallest integer above cnt that is not a multiple of the modulus.
    function automatic mstate_t advance(mstate_t s, int lim, int mod_in);
        mstate_t n;
        int v;
        v = s.cnt + 1;
        if (s.mod >= 2 && (v % s.mod) == 0)
            v = v + 1;
        n.mod  = s.mod;
        n.skip = 1'b0;
        n.wrap = 1'b0;
        if (v > lim || v >= (1 << BW)) begin
            n.cnt  = 0;
            n.mod  = mod_in;
            n.wrap = 1'b1;
        end else begin
            n.cnt  = v;
            n.skip = ((v - s.cnt) == 2);
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)
            m <= '{0, 3, 1'b0, 1'b0};
        else if (clr)
            m <= '{0, int'(mod_i), 1'b0, 1'b0};
        else if (en)
            m <= advance(m, int'(lim_i), int'(mod_i));
        else
            m <= '{m.cnt, m.mod, 1'b0, 1'b0};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_cnt", 32'(countout), 32'(m.cnt));
        check("model_skip", 32'(skip), 32'(m.skip));
        check("model_wrap", 32'(wrap), 32'(m.wrap));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int c, input bit s, input bit w);
        check({tag, "_cnt"}, 32'(countout), 32'(c));
        check({tag, "_skip"}, 32'(skip), 32'(s));
        check({tag, "_wrap"}, 32'(wrap), 32'(w));
    endtask

    task automatic do_clr(input int md);
        en    = 1'b0;
        clr   = 1'b1;
        mod_i = MW'(md);
        cyc();
        clr = 1'b0;
        expect3("clr", 0, 1'b0, 1'b0);
    endtask

    initial begin
        int seq1 [7] = '{1, 2, 4, 5, 7, 8, 10};
        bit sk1  [7] = '{0, 0, 1, 0, 1, 0, 1};
        int seq2 [4] = '{1, 3, 5, 7};
        bit sk2  [4] = '{0, 1, 1, 1};
        int seq3 [5] = '{1, 2, 4, 5, 7};
        bit sk3  [5] = '{0, 0, 1, 0, 1};

        rst   = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        mod_i = MW'(3);
        lim_i = 8'd255;
        #12;
        rst = 1'b0;
        expect3("reset", 0, 1'b0, 1'b0);

        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            expect3("mod3", seq1[i], sk1[i], 1'b0);
        end

        do_clr(2);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect3("mod2", seq2[i], sk2[i], 1'b0);
        end

        // Limit wrap; mod_i changed just before the wrap edge must take effect after it.
        lim_i = 8'd7;
        do_clr(3);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect3("lim7", seq3[i], sk3[i], 1'b0);
        end
        mod_i = MW'(2);
        cyc();
        expect3("lim7_wrap", 0, 1'b0, 1'b1);
        cyc();
        expect3("reload_a", 1, 1'b0, 1'b0);
        cyc();
        expect3("reload_b", 3, 1'b1, 1'b0);

        lim_i = 8'd255;
        do_clr(3);
        en = 1'b1;
        cyc(); cyc(); cyc();
        expect3("hold_pre", 4, 1'b1, 1'b0);
        en = 1'b0;
        cyc();
        expect3("hold1", 4, 1'b0, 1'b0);
        cyc();
        expect3("hold2", 4, 1'b0, 1'b0);
        en = 1'b1;
        cyc();
        expect3("resume", 5, 1'b0, 1'b0);
        mod_i = MW'(5);
        cyc();
        expect3("keep_mod_a", 7, 1'b1, 1'b0);
        cyc();
        expect3("keep_mod_b", 8, 1'b0, 1'b0);
        lim_i = 8'd5;
        cyc();
        expect3("lower_lim", 0, 1'b0, 1'b1);
        lim_i = 8'd255;
        cyc();
        expect3("after_lower", 1, 1'b0, 1'b0);

        do_clr(1);
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            expect3("mod1", i, 1'b0, 1'b0);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        expect3("clr_en", 0, 1'b0, 1'b0);

        lim_i = 8'd0;
        cyc();
        expect3("lim0_a", 0, 1'b0, 1'b1);
        cyc();
        expect3("lim0_b", 0, 1'b0, 1'b1);
        lim_i = 8'd255;

        do_clr(3);
        en = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        expect3("pre_rst", 5, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cnt", 32'(countout), 32'd0);
        mod_i = MW'(7);
        #2;
        rst = 1'b0;
        cyc();
        expect3("post_rst_a", 1, 1'b0, 1'b0);
        cyc();
        expect3("post_rst_b", 2, 1'b0, 1'b0);
        cyc();
        expect3("post_rst_c", 4, 1'b1, 1'b0);

        do_clr(3);
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (countout == 8'd254)
                break;
            cyc();
        end
        check("reach_254", 32'(countout), 32'd254);
        cyc();
        expect3("overflow", 0, 1'b0, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 19) == 0);
            mod_i = MW'($urandom_range(0, 15));
            lim_i = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, 255)) : 8'd255;
            cyc();
        end
        en  = 1'b0;
        clr = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
